serial_adder_seq: RTL and testbench



---
 rtl/serial_adder_seq.sv | 108 ++++++++++
 tb/tb_serial_adder_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: operands are accepted over valid/ready, added LSB-first
// through a single sum/carry cell, and the result is held on an output valid/ready handshake.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;
    logic             last_bit;
    logic             accept;

    // The 1-bit adder cell fed from the LSBs of the operand shift registers
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_bit    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign sum_next = {s_bit, sum_sh[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // sum/cout are only written on the final shift edge so partial results never show
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                    end
                end
                SHIFT: begin
                    sum_sh <= sum_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= c_bit;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= sum_next;
                        cout <= c_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq: expected {cout,sum} queued at accept,
// popped and compared when the result is taken.
module tb_serial_adder_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] exp_q[$];

    serial_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offers operands until accepted; returns at accept edge + 1
    task automatic applyStimulus(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
        a        = xa;
        b        = xb;
        cin      = xc;
        in_valid = 1'b1;
        exp_q.push_back({1'b0, xa} + {1'b0, xb} + {{WIDTH{1'b0}}, xc});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Waits for the result, optionally scrambling inputs and stalling, then takes it
    task automatic collectResult(input int hold, input bit scramble);
        int n = 0;
        logic [WIDTH:0] exp;
        logic [WIDTH-1:0] held_sum;
        logic held_cout;
        while (!out_valid && n < 40) begin
            if (scramble) begin
                a        = WIDTH'($urandom);
                b        = WIDTH'($urandom);
                cin      = 1'($urandom);
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!out_valid) checkOutput("busy_shift", {31'd0, busy}, 32'd1);
        end
        checkOutput("latency", n, WIDTH);
        held_sum  = sum;
        held_cout = cout;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a         = ~a;
            b         = b + 8'h11;
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_sum", {24'd0, sum}, {24'd0, held_sum});
            checkOutput("bp_cout", {31'd0, cout}, {31'd0, held_cout});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else exp = '1;
        checkOutput("sum", {24'd0, sum}, {24'd0, exp[WIDTH-1:0]});
        checkOutput("cout", {31'd0, cout}, {31'd0, exp[WIDTH]});
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("taken_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("taken_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 8'h12;
        b         = 8'h34;
        cin       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_sum", {24'd0, sum}, 32'd0);
        checkOutput("rst_cout", {31'd0, cout}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);

        applyStimulus(8'h5A, 8'h33, 1'b0);
        collectResult(0, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0);
        collectResult(0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        collectResult(5, 1'b0);

        // Abort mid-shift: previous sum (0xFF) must clear immediately
        applyStimulus(8'h0F, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("abort_sum", {24'd0, sum}, 32'd0);
        checkOutput("abort_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h0F, 8'h01, 1'b0);
        collectResult(0, 1'b0);

        applyStimulus(8'h00, 8'h00, 1'b1);
        collectResult(0, 1'b1);
        applyStimulus(8'hA5, 8'h5A, 1'b1);
        collectResult(0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            collectResult(int'($urandom_range(0, 3)), 1'b1);
        end

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
